// File: rtl/stack_engine_if.sv
// Command and observation bundle between the decoder/ALU and the stack engine.
// Latency: none; this file only carries wires.
// Backpressure: cmd_ready from the engine qualifies cmd_valid from the master.
interface stack_engine_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int RDEPTH = 16
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [3:0]                   cmd_op;
  logic [WIDTH-1:0]             cmd_din;
  logic [WIDTH-1:0]             tos;
  logic [WIDTH-1:0]             nos;
  logic [WIDTH-1:0]             ros;
  logic [WIDTH-1:0]             rtos;
  logic [$clog2(DEPTH+1)-1:0]   d_depth;
  logic [$clog2(RDEPTH+1)-1:0]  r_depth;
  logic                         err_under;
  logic                         err_over;
  logic                         err_illegal;
  logic                         err_clr;

  // Decoder / ALU side: issues commands and watches the stack tops.
  modport master (
    output cmd_valid, cmd_op, cmd_din, err_clr,
    input  cmd_ready, tos, nos, ros, rtos, d_depth, r_depth,
           err_under, err_over, err_illegal
  );

  // Engine side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_din, err_clr,
    output cmd_ready, tos, nos, ros, rtos, d_depth, r_depth,
           err_under, err_over, err_illegal
  );
endinterface

// File: rtl/stack_engine.sv
// Data/return stack unit: one stack command per cycle with sticky error trapping.
// Latency: result visible right after the accepting edge; back-to-back with no bubbles.
// Backpressure: cmd_ready drops while any error flag is set until err_clr.
module stack_engine #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int RDEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_engine_if.slave bus
);
  localparam int DW  = $clog2(DEPTH + 1);
  localparam int RW  = $clog2(RDEPTH + 1);
  localparam int DSW = DEPTH * WIDTH;
  localparam int RSW = RDEPTH * WIDTH;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_PUSH   = 4'd1;
  localparam logic [3:0] OP_DROP   = 4'd2;
  localparam logic [3:0] OP_DUP    = 4'd3;
  localparam logic [3:0] OP_SWAP   = 4'd4;
  localparam logic [3:0] OP_ROT    = 4'd5;
  localparam logic [3:0] OP_OVER   = 4'd6;
  localparam logic [3:0] OP_REPL2  = 4'd7;
  localparam logic [3:0] OP_REPL1  = 4'd8;
  localparam logic [3:0] OP_RPUSH  = 4'd9;
  localparam logic [3:0] OP_RPOP   = 4'd10;
  localparam logic [3:0] OP_RCP    = 4'd11;
  localparam logic [3:0] OP_RPUSHI = 4'd12;
  localparam logic [3:0] OP_RDROP  = 4'd13;

  // Element 0 is the top of each stack. Cells above the occupancy are kept at
  // zero (pops shift zeros in), so the top outputs need no depth masking.
  logic [DEPTH-1:0][WIDTH-1:0]  dstk_q, dstk_d, d_tmp;
  logic [RDEPTH-1:0][WIDTH-1:0] rstk_q, rstk_d, r_tmp;
  logic [DW-1:0]                d_cnt_q, d_cnt_d;
  logic [RW-1:0]                r_cnt_q, r_cnt_d;
  logic                         under_q, over_q, ill_q;
  logic                         under_d, over_d, ill_d;

  logic [1:0]       need_d;
  logic             need_r, d_grow, r_grow, illegal;
  logic             chk_under, chk_over, fire, exec;
  logic [1:0]       d_pop;
  logic             d_push, r_pop, r_push;
  logic [WIDTH-1:0] d_val, r_val;

  // Opcode decode: minimum occupancy and growth per stack.
  always_comb begin
    need_d  = 2'd0;
    need_r  = 1'b0;
    d_grow  = 1'b0;
    r_grow  = 1'b0;
    illegal = 1'b0;
    case (bus.cmd_op)
      OP_NOP:    ;
      OP_PUSH:   d_grow = 1'b1;
      OP_DROP:   need_d = 2'd1;
      OP_DUP:    begin need_d = 2'd1; d_grow = 1'b1; end
      OP_SWAP:   need_d = 2'd2;
      OP_ROT:    need_d = 2'd3;
      OP_OVER:   begin need_d = 2'd2; d_grow = 1'b1; end
      OP_REPL2:  need_d = 2'd2;
      OP_REPL1:  need_d = 2'd1;
      OP_RPUSH:  begin need_d = 2'd1; r_grow = 1'b1; end
      OP_RPOP:   begin need_r = 1'b1; d_grow = 1'b1; end
      OP_RCP:    begin need_r = 1'b1; d_grow = 1'b1; end
      OP_RPUSHI: r_grow = 1'b1;
      OP_RDROP:  need_r = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  // Checks in priority order: illegal, then underflow, then overflow.
  always_comb begin
    chk_under = (32'(d_cnt_q) < 32'(need_d)) || (32'(r_cnt_q) < 32'(need_r));
    chk_over  = (d_grow && (32'(d_cnt_q) == DEPTH)) ||
                (r_grow && (32'(r_cnt_q) == RDEPTH));
    fire      = bus.cmd_valid && bus.cmd_ready;
    exec      = fire && !illegal && !chk_under && !chk_over;
    // err_clr overrides any flag raised in the same cycle.
    ill_d     = bus.err_clr ? 1'b0 : (ill_q   | (fire && illegal));
    under_d   = bus.err_clr ? 1'b0 : (under_q | (fire && !illegal && chk_under));
    over_d    = bus.err_clr ? 1'b0 : (over_q  | (fire && !illegal && !chk_under && chk_over));
  end

  // Stack datapath: every op is "pop n, optionally push one value", with SWAP
  // and ROT handled as in-place permutations of the top cells.
  always_comb begin
    d_pop  = 2'd0;
    d_push = 1'b0;
    d_val  = '0;
    r_pop  = 1'b0;
    r_push = 1'b0;
    r_val  = '0;
    if (exec) begin
      case (bus.cmd_op)
        OP_PUSH:   begin d_push = 1'b1; d_val = bus.cmd_din; end
        OP_DROP:   d_pop = 2'd1;
        OP_DUP:    begin d_push = 1'b1; d_val = dstk_q[0]; end
        OP_OVER:   begin d_push = 1'b1; d_val = dstk_q[1]; end
        OP_REPL2:  begin d_pop = 2'd2; d_push = 1'b1; d_val = bus.cmd_din; end
        OP_REPL1:  begin d_pop = 2'd1; d_push = 1'b1; d_val = bus.cmd_din; end
        OP_RPUSH:  begin d_pop = 2'd1; r_push = 1'b1; r_val = dstk_q[0]; end
        OP_RPOP:   begin r_pop = 1'b1; d_push = 1'b1; d_val = rstk_q[0]; end
        OP_RCP:    begin d_push = 1'b1; d_val = rstk_q[0]; end
        OP_RPUSHI: begin r_push = 1'b1; r_val = bus.cmd_din; end
        OP_RDROP:  r_pop = 1'b1;
        default:   ;
      endcase
    end
    d_tmp  = dstk_q >> (WIDTH * int'(d_pop));
    dstk_d = d_push ? ((d_tmp << WIDTH) | DSW'(d_val)) : d_tmp;
    r_tmp  = r_pop ? (rstk_q >> WIDTH) : rstk_q;
    rstk_d = r_push ? ((r_tmp << WIDTH) | RSW'(r_val)) : r_tmp;
    if (exec && bus.cmd_op == OP_SWAP) begin
      dstk_d[0] = dstk_q[1];
      dstk_d[1] = dstk_q[0];
    end
    if (exec && bus.cmd_op == OP_ROT) begin
      dstk_d[0] = dstk_q[2];
      dstk_d[1] = dstk_q[0];
      dstk_d[2] = dstk_q[1];
    end
    d_cnt_d = d_cnt_q - DW'(d_pop) + DW'(d_push);
    r_cnt_d = r_cnt_q - RW'(r_pop) + RW'(r_push);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstk_q  <= '0;
      rstk_q  <= '0;
      d_cnt_q <= '0;
      r_cnt_q <= '0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      dstk_q  <= dstk_d;
      rstk_q  <= rstk_d;
      d_cnt_q <= d_cnt_d;
      r_cnt_q <= r_cnt_d;
      under_q <= under_d;
      over_q  <= over_d;
      ill_q   <= ill_d;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    bus.cmd_ready   = !(under_q | over_q | ill_q);
    bus.tos         = dstk_q[0];
    bus.nos         = dstk_q[1];
    bus.ros         = dstk_q[2];
    bus.rtos        = rstk_q[0];
    bus.d_depth     = d_cnt_q;
    bus.r_depth     = r_cnt_q;
    bus.err_under   = under_q;
    bus.err_over    = over_q;
    bus.err_illegal = ill_q;
  end
endmodule
